hack_mem_router: RTL and testbench
==================================

Name: hack_mem_router

Overview:
Sequential front end for the data-memory map. It accepts one CPU load/store request at a time over a valid/ready handshake and decodes address bits [14:13] into four one-hot region selects (RAM low, RAM high, screen, keyboard), the same function as a 4-way demux with `in` = request strobe. It then runs the transfer to the selected target and returns read data on a response handshake. Upstream is the CPU/fetch-execute stage; downstream are the RAM16K and screen memories and the keyboard register.

Parameters:
ADDR_W, 15, request address width (Hack data space)
DATA_W, 16, data word width
KBD_ADDR, 15'h6000, only valid address in region 11

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  router can accept
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  load data valid
rsp_ready  in  1  CPU accepts response
rsp_rdata  out  DATA_W  load data
rsp_err  out  1  load hit an unmapped address; data is 0
ram_valid  out  1  RAM command valid (regions 00, 01)
ram_ready  in  1  RAM accepts command
ram_we  out  1  RAM store
ram_addr  out  14  req_addr[13:0]
ram_wdata  out  DATA_W  store data
ram_rvalid  in  1  RAM load data valid
ram_rdata  in  DATA_W  RAM load data
scr_valid, scr_ready, scr_we, scr_wdata, scr_rvalid, scr_rdata  same as ram_*; scr_addr out 13 = req_addr[12:0]
kbd_data  in  DATA_W  keyboard register, read combinationally

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE. req_ready=1 after release. rsp_valid=0, rsp_err=0, rsp_rdata=0. ram_valid=scr_valid=0. All latched fields cleared.
- Decode sel=req_addr[14:13]. 00/01 → RAM, 10 → screen, 11 → keyboard. Exactly one select is active per accepted request.
- States: IDLE, ISSUE, WAIT_RD, RESP.
- IDLE:
  - req_ready=1. Accept on req_valid&req_ready; latch we/addr/wdata/sel.
  - RAM or screen target → ISSUE.
  - Keyboard load with addr==KBD_ADDR → capture kbd_data at the accept edge → RESP with rsp_err=0.
  - Keyboard load with any other address → RESP with rsp_rdata=0, rsp_err=1.
  - Keyboard store (any address) → dropped, stay IDLE; no response.
- ISSUE:
  - Assert the selected target's valid with latched fields; hold them stable until that target's ready=1.
  - On accept: store → IDLE; load → WAIT_RD.
  - Minimum latency: accept edge T, target valid high in cycle T+1.
- WAIT_RD: on the selected target's rvalid, capture its rdata → RESP. rvalid from the non-selected target is ignored.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1 → IDLE.
  - req_ready=0 in every state except IDLE, so one transaction is outstanding at a time.
- rvalid arriving in IDLE, ISSUE or RESP is ignored and not buffered.
- Reset mid-transaction aborts immediately: target valid drops at the next edge, and no response is issued.
- Keyboard load best case: accept at T, rsp_valid at T+1. Back-to-back keyboard loads run at one per 2 cycles when rsp_ready is held at 1.

Decomposition:
- Shared package holds:
  - region codes REG_RAM0=2'b00, REG_RAM1=2'b01, REG_SCR=2'b10, REG_KBD=2'b11
  - state encoding localparams
  - KBD_ADDR, DATA_W
- One sub-module, hack_region_decode: combinational 2-to-4 one-hot decode of req_addr[14:13] gated by req_valid. Instantiated once.

Test Plan:
1. Store addr=0x0005 data=0x1234, ram_ready=1 → ram_valid high for exactly 1 cycle at T+1 with ram_addr=0x0005, ram_we=1, ram_wdata=0x1234; scr_valid stays 0; req_ready back to 1 at T+2.
2. Load addr=0x4010, scr_ready low for 3 cycles, scr_rvalid 2 cycles after accept with scr_rdata=0xBEEF → scr_valid held 4 cycles with scr_addr=0x0010 stable; then rsp_valid=1, rsp_rdata=0xBEEF, rsp_err=0.
3. Load 0x6000 with kbd_data=0x0041 → rsp_valid at T+1, rsp_rdata=0x0041. Load 0x6001 → rsp_rdata=0, rsp_err=1. Store 0x6000 → no target valid, no response.
4. Response backpressure: RAM load returns 0xAAAA, rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable; req_ready=0 throughout; a new req_valid is not accepted until after the rsp_ready handshake.
5. Assert rst_n=0 for 1 cycle during WAIT_RD of a RAM load → ram_valid=0, rsp_valid=0, req_ready=1 after release. A late ram_rvalid with 0x5555 produces no response.
6. Region sweep with loads at 0x0000, 0x2000, 0x4000, 0x6000 → each selects exactly RAM, RAM, screen, keyboard respectively; never two target valids in the same cycle.

Source files
------------

// File: rtl/hack_mem_router_pkg.sv
// Shared constants for the Hack data-memory router: widths, region codes,
// keyboard address and FSM state encoding.
package hack_mem_router_pkg;

  localparam int HACK_ADDR_W = 15;
  localparam int HACK_DATA_W = 16;
  localparam logic [HACK_ADDR_W-1:0] HACK_KBD_ADDR = 15'h6000;

  localparam logic [1:0] REG_RAM0 = 2'b00;
  localparam logic [1:0] REG_RAM1 = 2'b01;
  localparam logic [1:0] REG_SCR  = 2'b10;
  localparam logic [1:0] REG_KBD  = 2'b11;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;
  localparam logic [1:0] ST_RESP    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_ISSUE   = ST_ISSUE,
    S_WAIT_RD = ST_WAIT_RD,
    S_RESP    = ST_RESP
  } state_t;

endpackage

// File: rtl/hack_mem_router_if.sv
// Bus bundle between the CPU, the router and the RAM/screen/keyboard targets.
// slave = router view, master = surrounding CPU and memories.
interface hack_mem_router_if #(
  parameter int ADDR_W = hack_mem_router_pkg::HACK_ADDR_W,
  parameter int DATA_W = hack_mem_router_pkg::HACK_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              ram_valid;
  logic              ram_ready;
  logic              ram_we;
  logic [13:0]       ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_rvalid;
  logic [DATA_W-1:0] ram_rdata;

  logic              scr_valid;
  logic              scr_ready;
  logic              scr_we;
  logic [12:0]       scr_addr;
  logic [DATA_W-1:0] scr_wdata;
  logic              scr_rvalid;
  logic [DATA_W-1:0] scr_rdata;

  logic [DATA_W-1:0] kbd_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
           ram_ready, ram_rvalid, ram_rdata,
           scr_ready, scr_rvalid, scr_rdata, kbd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           ram_valid, ram_we, ram_addr, ram_wdata,
           scr_valid, scr_we, scr_addr, scr_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
           ram_ready, ram_rvalid, ram_rdata,
           scr_ready, scr_rvalid, scr_rdata, kbd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           ram_valid, ram_we, ram_addr, ram_wdata,
           scr_valid, scr_we, scr_addr, scr_wdata
  );

endinterface

// File: rtl/hack_mem_router_decode.sv
// 2-to-4 one-hot region decode of the request address, gated by the strobe.
module hack_region_decode
  import hack_mem_router_pkg::*;
(
  input  logic       req_valid,
  input  logic [1:0] sel,
  output logic [3:0] sel_oh
);

  always_comb begin
    sel_oh = '0;
    if (req_valid) begin
      case (sel)
        REG_RAM0: sel_oh[REG_RAM0] = 1'b1;
        REG_RAM1: sel_oh[REG_RAM1] = 1'b1;
        REG_SCR:  sel_oh[REG_SCR]  = 1'b1;
        default:  sel_oh[REG_KBD]  = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/hack_mem_router.sv
// Data-memory router: accepts one CPU load/store, forwards it to RAM or screen,
// or serves the keyboard register directly, and returns load data.
//
// state   | meaning
// IDLE    | ready for a request; keyboard accesses resolved here
// ISSUE   | target command valid, waiting for target ready
// WAIT_RD | load issued, waiting for the selected target's rvalid
// RESP    | response valid, held until the CPU accepts it
module hack_mem_router
  import hack_mem_router_pkg::*;
#(
  parameter int ADDR_W = HACK_ADDR_W,
  parameter int DATA_W = HACK_DATA_W,
  parameter logic [ADDR_W-1:0] KBD_ADDR = HACK_KBD_ADDR
) (
  input  logic clk,
  input  logic rst_n,
  hack_mem_router_if.slave bus
);

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [13:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              tgt_ram_q, tgt_ram_d;
  logic              tgt_scr_q, tgt_scr_d;

  logic [3:0] sel_oh;
  logic       req_ready_o;
  logic       rsp_valid_o;
  logic       ram_valid_o;
  logic       scr_valid_o;

  hack_region_decode u_decode (
    .req_valid (bus.req_valid),
    .sel       (bus.req_addr[ADDR_W-1 -: 2]),
    .sel_oh    (sel_oh)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    tgt_ram_d   = tgt_ram_q;
    tgt_scr_d   = tgt_scr_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    ram_valid_o = 1'b0;
    scr_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (bus.req_valid) begin
          we_d      = bus.req_we;
          addr_d    = bus.req_addr[13:0];
          wdata_d   = bus.req_wdata;
          tgt_ram_d = sel_oh[REG_RAM0] | sel_oh[REG_RAM1];
          tgt_scr_d = sel_oh[REG_SCR];
        end
        // Keyboard stores are silently dropped; loads answer without a target cycle.
        if (sel_oh[REG_KBD]) begin
          if (!bus.req_we) begin
            state_d = S_RESP;
            if (bus.req_addr == KBD_ADDR) begin
              rdata_d = bus.kbd_data;
              err_d   = 1'b0;
            end else begin
              rdata_d = '0;
              err_d   = 1'b1;
            end
          end
        end else if (sel_oh[REG_RAM0] | sel_oh[REG_RAM1] | sel_oh[REG_SCR]) begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        ram_valid_o = tgt_ram_q;
        scr_valid_o = tgt_scr_q;
        if ((tgt_ram_q && bus.ram_ready) || (tgt_scr_q && bus.scr_ready)) begin
          state_d = we_q ? S_IDLE : S_WAIT_RD;
        end
      end

      S_WAIT_RD: begin
        if (tgt_ram_q && bus.ram_rvalid) begin
          rdata_d = bus.ram_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tgt_scr_q && bus.scr_rvalid) begin
          rdata_d = bus.scr_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      tgt_ram_q <= 1'b0;
      tgt_scr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      tgt_ram_q <= tgt_ram_d;
      tgt_scr_q <= tgt_scr_d;
    end
  end

  assign bus.req_ready = req_ready_o;
  assign bus.rsp_valid = rsp_valid_o;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  assign bus.ram_valid = ram_valid_o;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

  assign bus.scr_valid = scr_valid_o;
  assign bus.scr_we    = we_q;
  assign bus.scr_addr  = addr_q[12:0];
  assign bus.scr_wdata = wdata_q;

endmodule

// File: tb/tb_hack_mem_router.sv
// Directed bench for hack_mem_router: a vector table of single transactions
// plus hand-written sequences for backpressure, timing and reset corners.
module tb_hack_mem_router;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hack_mem_router_if bus ();

  hack_mem_router dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic [15:0] kbd;
    logic [15:0] mem_rdata;
    int          exp_tgt;     // 0 none, 1 RAM, 2 screen
    logic [13:0] exp_taddr;
    logic        exp_rsp;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  task automatic run_vec(input int i);
    vec_t v;
    int   tgt, tcyc, pend;
    logic got_rsp, done, twe;
    logic [15:0] rdata, twd;
    logic        err;
    logic [13:0] taddr;
    v = vecs[i];
    tgt = 0; tcyc = 0; pend = 0;
    got_rsp = 1'b0; done = 1'b0; twe = 1'b0;
    rdata = '0; twd = '0; err = 1'b0; taddr = '0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_ready", i), bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = v.we;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.kbd_data  = v.kbd;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("v%0d_one_target", i), bus.ram_valid & bus.scr_valid, 0);
      if (bus.ram_valid) begin
        tgt = 1; tcyc++; taddr = bus.ram_addr; twe = bus.ram_we; twd = bus.ram_wdata;
      end
      if (bus.scr_valid) begin
        tgt = 2; tcyc++; taddr = {1'b0, bus.scr_addr}; twe = bus.scr_we; twd = bus.scr_wdata;
      end
      if (bus.rsp_valid) begin
        got_rsp = 1'b1; rdata = bus.rsp_rdata; err = bus.rsp_err;
      end
      bus.ram_rvalid = 1'b0;
      bus.scr_rvalid = 1'b0;
      if (pend == 1) begin
        bus.ram_rvalid = 1'b1; bus.ram_rdata = v.mem_rdata;
      end else if (pend == 2) begin
        bus.scr_rvalid = 1'b1; bus.scr_rdata = v.mem_rdata;
      end
      pend = 0;
      if (!v.we && bus.ram_valid) pend = 1;
      else if (!v.we && bus.scr_valid) pend = 2;
      if (bus.req_ready) done = 1'b1;
    end
    chk($sformatf("v%0d_done", i), done, 1);
    chk($sformatf("v%0d_target", i), tgt, v.exp_tgt);
    chk($sformatf("v%0d_tgt_cycles", i), tcyc, (v.exp_tgt != 0) ? 1 : 0);
    if (v.exp_tgt != 0) begin
      chk($sformatf("v%0d_taddr", i), taddr, v.exp_taddr);
      chk($sformatf("v%0d_twe", i), twe, v.we);
      if (v.we) chk($sformatf("v%0d_twdata", i), twd, v.wdata);
    end
    chk($sformatf("v%0d_rsp", i), got_rsp, v.exp_rsp);
    if (v.exp_rsp) begin
      chk($sformatf("v%0d_rdata", i), rdata, v.exp_rdata);
      chk($sformatf("v%0d_err", i), err, v.exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    //          we    addr      wdata     kbd       mem       tgt taddr     rsp   rdata     err
    vecs[0] = '{1'b1, 15'h0005, 16'h1234, 16'h0000, 16'h0000, 1, 14'h0005, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 15'h0000, 16'h0000, 16'h0000, 16'h1111, 1, 14'h0000, 1'b1, 16'h1111, 1'b0};
    vecs[2] = '{1'b0, 15'h2000, 16'h0000, 16'h0000, 16'h2222, 1, 14'h2000, 1'b1, 16'h2222, 1'b0};
    vecs[3] = '{1'b0, 15'h4000, 16'h0000, 16'h0000, 16'h3333, 2, 14'h0000, 1'b1, 16'h3333, 1'b0};
    vecs[4] = '{1'b0, 15'h6000, 16'h0000, 16'h0041, 16'h0000, 0, 14'h0000, 1'b1, 16'h0041, 1'b0};
    vecs[5] = '{1'b0, 15'h6001, 16'h0000, 16'h0041, 16'h0000, 0, 14'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[6] = '{1'b1, 15'h6000, 16'hCAFE, 16'h0041, 16'h0000, 0, 14'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[7] = '{1'b1, 15'h5ABC, 16'h0F0F, 16'h0000, 16'h0000, 2, 14'h1ABC, 1'b0, 16'h0000, 1'b0};
    vecs[8] = '{1'b0, 15'h3FFF, 16'h0000, 16'h0000, 16'h8001, 1, 14'h3FFF, 1'b1, 16'h8001, 1'b0};
    vecs[9] = '{1'b0, 15'h7FFF, 16'h0000, 16'h1234, 16'h0000, 0, 14'h0000, 1'b1, 16'h0000, 1'b1};

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    bus.ram_ready = 1'b1; bus.ram_rvalid = 1'b0; bus.ram_rdata = '0;
    bus.scr_ready = 1'b1; bus.scr_rvalid = 1'b0; bus.scr_rdata = '0;
    bus.kbd_data  = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_ram_valid", bus.ram_valid, 0);
    chk("rst_scr_valid", bus.scr_valid, 0);

    // RAM store timing: valid exactly at T+1, ready again at T+2
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 15'h0005; bus.req_wdata = 16'h1234;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("st_ram_valid", bus.ram_valid, 1);
    chk("st_ram_addr", bus.ram_addr, 14'h0005);
    chk("st_ram_we", bus.ram_we, 1);
    chk("st_ram_wdata", bus.ram_wdata, 16'h1234);
    chk("st_scr_valid", bus.scr_valid, 0);
    chk("st_req_ready_busy", bus.req_ready, 0);
    @(negedge clk);
    chk("st_ram_valid_drop", bus.ram_valid, 0);
    chk("st_req_ready_back", bus.req_ready, 1);

    for (int i = 0; i < 10; i++) run_vec(i);

    // Screen load with command backpressure and a stray RAM rvalid
    @(negedge clk);
    bus.scr_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 15'h4010;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk($sformatf("scr_hold%0d_valid", k), bus.scr_valid, 1);
      chk($sformatf("scr_hold%0d_addr", k), bus.scr_addr, 13'h0010);
      chk($sformatf("scr_hold%0d_ram", k), bus.ram_valid, 0);
      if (k == 4) bus.scr_ready = 1'b1;
    end
    @(negedge clk);
    chk("scr_valid_drop", bus.scr_valid, 0);
    chk("scr_no_rsp_yet", bus.rsp_valid, 0);
    bus.ram_rvalid = 1'b1; bus.ram_rdata = 16'hDEAD;
    @(negedge clk);
    chk("scr_ignores_ram_rvalid", bus.rsp_valid, 0);
    bus.scr_rvalid = 1'b1; bus.scr_rdata = 16'hBEEF;
    @(negedge clk);
    bus.ram_rvalid = 1'b0; bus.scr_rvalid = 1'b0;
    chk("scr_rsp_valid", bus.rsp_valid, 1);
    chk("scr_rsp_rdata", bus.rsp_rdata, 16'hBEEF);
    chk("scr_rsp_err", bus.rsp_err, 0);
    @(negedge clk);
    chk("scr_rsp_done", bus.rsp_valid, 0);
    chk("scr_req_ready", bus.req_ready, 1);

    // Keyboard load latency and back-to-back rate
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 15'h6000; bus.kbd_data = 16'h0041;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.kbd_data = 16'h0099;
    chk("kbd_rsp_t1", bus.rsp_valid, 1);
    chk("kbd_rdata_t1", bus.rsp_rdata, 16'h0041);
    chk("kbd_busy_t1", bus.req_ready, 0);
    @(negedge clk);
    chk("kbd_rsp_t2", bus.rsp_valid, 0);
    chk("kbd_ready_t2", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 5) bus.req_valid = 1'b0;
      if (bus.rsp_valid) cnt++;
    end
    chk("kbd_b2b_count", cnt, 3);
    chk("kbd_b2b_rdata", bus.rsp_rdata, 16'h0099);

    // Response backpressure; a waiting request must not slip in
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 15'h0100;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_ram_valid", bus.ram_valid, 1);
    @(negedge clk);
    chk("bp_no_rsp", bus.rsp_valid, 0);
    bus.ram_rvalid = 1'b1; bus.ram_rdata = 16'hAAAA;
    @(negedge clk);
    bus.ram_rvalid = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 15'h0007; bus.req_wdata = 16'h7777;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("bp%0d_rsp_valid", k), bus.rsp_valid, 1);
      chk($sformatf("bp%0d_rsp_rdata", k), bus.rsp_rdata, 16'hAAAA);
      chk($sformatf("bp%0d_req_ready", k), bus.req_ready, 0);
      chk($sformatf("bp%0d_ram_valid", k), bus.ram_valid, 0);
      if (k == 4) bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("bp_rsp_gone", bus.rsp_valid, 0);
    chk("bp_req_ready", bus.req_ready, 1);
    chk("bp_not_early", bus.ram_valid, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_next_valid", bus.ram_valid, 1);
    chk("bp_next_addr", bus.ram_addr, 14'h0007);
    chk("bp_next_we", bus.ram_we, 1);
    chk("bp_next_wdata", bus.ram_wdata, 16'h7777);
    @(negedge clk);
    chk("bp_next_idle", bus.req_ready, 1);

    // Reset during WAIT_RD aborts; late rvalid produces nothing
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 15'h0200;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rm_ram_valid", bus.ram_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rm_ram_valid_off", bus.ram_valid, 0);
    chk("rm_rsp_valid", bus.rsp_valid, 0);
    chk("rm_req_ready", bus.req_ready, 1);
    chk("rm_rsp_rdata", bus.rsp_rdata, 0);
    bus.ram_rvalid = 1'b1; bus.ram_rdata = 16'h5555;
    @(negedge clk);
    bus.ram_rvalid = 1'b0;
    chk("rm_late_rsp1", bus.rsp_valid, 0);
    @(negedge clk);
    chk("rm_late_rsp2", bus.rsp_valid, 0);
    chk("rm_late_ready", bus.req_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
